// File: rtl/hash_msg_feeder_if.sv
// Host/core handshake bundle for the hash message feeder.
// slave = feeder side, master = host/core side.
interface hash_msg_feeder_if #(
    parameter int LEN_W = 64
);
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic             hash_ready;
    logic             M_valid;
    logic [7:0]       message;
    logic [LEN_W-1:0] counter;
    logic             busy;
    logic             done;
    logic             len_err;

    modport slave (
        input  start, msg_len, in_byte, in_valid, hash_ready,
        output in_ready, M_valid, message, counter, busy, done, len_err
    );

    modport master (
        output start, msg_len, in_byte, in_valid, hash_ready,
        input  in_ready, M_valid, message, counter, busy, done, len_err
    );
endinterface

// File: rtl/hash_msg_feeder.sv
// Byte-stream feeder in front of the DES-S-box hash core.
// Optional abort input enabled by HASH_FEEDER_ABORT_EN.
module hash_msg_feeder #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 64
) (
    input  logic clk,
    input  logic rst_n,
`ifdef HASH_FEEDER_ABORT_EN
    input  logic abort,
`endif
    hash_msg_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]       r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [LEN_W-1:0] r_rx_left;
    logic [LEN_W-1:0] r_tx_left;
    logic [LEN_W-1:0] r_counter;
    logic [7:0]       r_message;
    logic             r_mvalid;
    logic             r_busy;
    logic             r_done;
    logic             r_len_err;

    logic w_abort;
    logic w_abort_act;
    logic w_full;
    logic w_empty;
    logic w_in_ready;
    logic w_push;
    logic w_pop;
    logic w_start_ok;
    logic w_start_zero;

`ifdef HASH_FEEDER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_abort_act  = w_abort && (r_state != S_IDLE);
    assign w_full       = (r_wptr[AW] != r_rptr[AW]) &&
                          (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty      = (r_wptr == r_rptr);
    assign w_in_ready   = (r_state == S_STREAM) && !w_full &&
                          (r_rx_left != '0);
    assign w_push       = bus.in_valid && w_in_ready && !w_abort_act;
    assign w_pop        = (r_state == S_STREAM) && !w_empty &&
                          (r_tx_left != '0) && !w_abort_act;
    assign w_start_ok   = (r_state == S_IDLE) && bus.start &&
                          (bus.msg_len != '0);
    assign w_start_zero = (r_state == S_IDLE) && bus.start &&
                          (bus.msg_len == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next = S_STREAM;
            end
            S_STREAM: begin
                if (w_abort_act)
                    w_next = S_IDLE;
                else if (w_pop && r_tx_left == LEN_W'(1))
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_abort_act || bus.hash_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.in_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rx_left <= '0;
            r_tx_left <= '0;
            r_counter <= '0;
            r_message <= '0;
            r_mvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_busy    <= (w_next != S_IDLE);
            r_done    <= (r_state == S_WAIT) && bus.hash_ready &&
                         !w_abort_act;
            r_len_err <= w_start_zero;
            if (w_abort_act) begin
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_rx_left <= '0;
                r_tx_left <= '0;
                r_mvalid  <= 1'b0;
            end else begin
                if (w_start_ok) begin
                    r_counter <= bus.msg_len;
                    r_rx_left <= bus.msg_len;
                    r_tx_left <= bus.msg_len;
                end
                if (w_push) begin
                    r_wptr    <= r_wptr + 1'b1;
                    r_rx_left <= r_rx_left - LEN_W'(1);
                end
                r_mvalid <= w_pop;
                if (w_pop) begin
                    r_rptr    <= r_rptr + 1'b1;
                    r_tx_left <= r_tx_left - LEN_W'(1);
                    r_message <= r_mem[r_rptr[AW-1:0]];
                end
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.M_valid  = r_mvalid;
    assign bus.message  = r_message;
    assign bus.counter  = r_counter;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.len_err  = r_len_err;
endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder.
// Covers streaming, zero length, bursts, gaps, reset and abort.
module tb_hash_msg_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef HASH_FEEDER_ABORT_EN
    logic abort = 1'b0;
`endif
    int npass = 0;
    int ntot  = 0;

    hash_msg_feeder_if #(.LEN_W(64)) bus ();

    hash_msg_feeder #(
        .DEPTH(8),
        .LEN_W(64)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef HASH_FEEDER_ABORT_EN
        .abort(abort),
`endif
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_mvalid"}, 64'(bus.M_valid), 64'd0);
        chk({tag, "_message"}, 64'(bus.message), 64'd0);
        chk({tag, "_counter"}, bus.counter, 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_len_err"}, 64'(bus.len_err), 64'd0);
    endtask

    logic [7:0] b4 [4];
    logic [7:0] g3 [3];
    int acc;
    int beats;
    logic rdy;

    initial begin
        b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33; b4[3] = 8'h44;
        g3[0] = 8'hA5; g3[1] = 8'h5A; g3[2] = 8'hC3;
        bus.start = 0; bus.msg_len = '0; bus.in_byte = '0;
        bus.in_valid = 0; bus.hash_ready = 0;

        #12;
        chk_all_zero("rst");
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Basic stream of 4 back-to-back bytes
        bus.start = 1; bus.msg_len = 64'd4;
        tick();
        bus.start = 0;
        chk("b_counter", bus.counter, 64'd4);
        chk("b_busy", 64'(bus.busy), 64'd1);
        chk("b_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                bus.in_valid = 1; bus.in_byte = b4[i];
            end else begin
                bus.in_valid = 0;
            end
            tick();
            if (i >= 1 && i <= 4) begin
                chk("b_mvalid", 64'(bus.M_valid), 64'd1);
                chk("b_msg", 64'(bus.message), 64'(b4[i-1]));
                chk("b_cnt_hold", bus.counter, 64'd4);
            end
            if (i == 4) chk("b_rdy_end", 64'(bus.in_ready), 64'd0);
            if (i == 5) begin
                chk("b_mv_off", 64'(bus.M_valid), 64'd0);
                chk("b_busy_wait", 64'(bus.busy), 64'd1);
            end
        end
        tick();
        bus.hash_ready = 1;
        tick();
        bus.hash_ready = 0;
        chk("b_done", 64'(bus.done), 64'd1);
        chk("b_busy_off", 64'(bus.busy), 64'd0);
        tick();
        chk("b_done_pulse", 64'(bus.done), 64'd0);

        // Zero-length request
        bus.start = 1; bus.msg_len = 64'd0;
        tick();
        bus.start = 0;
        chk("z_len_err", 64'(bus.len_err), 64'd1);
        chk("z_busy", 64'(bus.busy), 64'd0);
        chk("z_in_ready", 64'(bus.in_ready), 64'd0);
        chk("z_cnt_keep", bus.counter, 64'd4);
        tick();
        chk("z_len_err_pulse", 64'(bus.len_err), 64'd0);
        chk("z_busy2", 64'(bus.busy), 64'd0);

        // Continuous 20-byte burst; 21st byte offered but refused
        bus.start = 1; bus.msg_len = 64'd20;
        tick();
        bus.start = 0;
        acc = 0; beats = 0;
        bus.in_valid = 1;
        for (int c = 0; c < 30; c++) begin
            bus.in_byte = 8'(8'h40 + acc);
            rdy = bus.in_ready;
            tick();
            if (rdy) acc++;
            if (bus.M_valid) begin
                chk("bp_byte", 64'(bus.message), 64'(8'h40 + beats));
                beats++;
            end
        end
        chk("bp_accepted", 64'(acc), 64'd20);
        chk("bp_beats", 64'(beats), 64'd20);
        chk("bp_rdy_after", 64'(bus.in_ready), 64'd0);
        chk("bp_busy", 64'(bus.busy), 64'd1);
        bus.in_valid = 0;
        bus.hash_ready = 1;
        tick();
        bus.hash_ready = 0;
        chk("bp_done", 64'(bus.done), 64'd1);

        // Host bytes spaced 5 cycles apart
        tick();
        bus.start = 1; bus.msg_len = 64'd3;
        tick();
        bus.start = 0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1; bus.in_byte = g3[k];
            tick();
            bus.in_valid = 0;
            chk("g_mv_gap", 64'(bus.M_valid), 64'd0);
            if (k == 2) bus.hash_ready = 1;
            tick();
            chk("g_mvalid", 64'(bus.M_valid), 64'd1);
            chk("g_msg", 64'(bus.message), 64'(g3[k]));
            if (k < 2) begin
                tick();
                chk("g_mv_idle", 64'(bus.M_valid), 64'd0);
                tick();
                tick();
            end
        end
        chk("g_busy_wait", 64'(bus.busy), 64'd1);
        chk("g_rdy_wait", 64'(bus.in_ready), 64'd0);
        chk("g_done_not_yet", 64'(bus.done), 64'd0);
        tick();
        bus.hash_ready = 0;
        chk("g_done_entry", 64'(bus.done), 64'd1);
        chk("g_busy_off", 64'(bus.busy), 64'd0);

        // Reset mid-message
        bus.start = 1; bus.msg_len = 64'd6;
        tick();
        bus.start = 0;
        bus.in_valid = 1; bus.in_byte = 8'hE1;
        tick();
        bus.in_byte = 8'hE2;
        tick();
        bus.in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("mr");
        @(negedge clk) rst_n = 1'b1;
        tick();
        bus.start = 1; bus.msg_len = 64'd2;
        tick();
        bus.start = 0;
        bus.in_valid = 1; bus.in_byte = 8'hB1;
        tick();
        chk("mr_no_stale", 64'(bus.M_valid), 64'd0);
        bus.in_byte = 8'hB2;
        tick();
        bus.in_valid = 0;
        chk("mr_mv1", 64'(bus.M_valid), 64'd1);
        chk("mr_b1", 64'(bus.message), 64'hB1);
        tick();
        chk("mr_mv2", 64'(bus.M_valid), 64'd1);
        chk("mr_b2", 64'(bus.message), 64'hB2);
        chk("mr_cnt", bus.counter, 64'd2);
        bus.hash_ready = 1;
        tick();
        bus.hash_ready = 0;
        chk("mr_done", 64'(bus.done), 64'd1);
        tick();

`ifdef HASH_FEEDER_ABORT_EN
        // Abort after 3 of 10 bytes
        bus.start = 1; bus.msg_len = 64'd10;
        tick();
        bus.start = 0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1; bus.in_byte = 8'(8'h70 + k);
            tick();
        end
        bus.in_valid = 0;
        abort = 1;
        tick();
        abort = 0;
        chk("ab_mvalid", 64'(bus.M_valid), 64'd0);
        chk("ab_busy", 64'(bus.busy), 64'd0);
        chk("ab_counter", bus.counter, 64'd10);
        chk("ab_rdy", 64'(bus.in_ready), 64'd0);
        bus.hash_ready = 1;
        tick();
        bus.hash_ready = 0;
        chk("ab_no_done", 64'(bus.done), 64'd0);
        chk("ab_mv_flushed", 64'(bus.M_valid), 64'd0);
        tick();
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
